// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one square-root unit among NUM_REQ requesters.
// A watchdog releases the unit when the completion pulse never arrives.
module sqrt_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned RES_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] operand_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [RES_W-1:0]          result_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic                      sq_start_o,
    output logic [DATA_W-1:0]         sq_operand_o,
    input  logic                      sq_done_i,
    input  logic [RES_W-1:0]          sq_root_i
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic [RES_W-1:0]    r_result;
    logic                r_err;
    logic                r_busy;
    logic                r_start;
    logic [DATA_W-1:0]   r_operand;
    logic [IDX_W-1:0]    r_win;
    logic [IDX_W-1:0]    r_rr;
    logic [CNT_W-1:0]    r_cnt;

    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [NUM_REQ-1:0]  w_done_nxt;
    logic [RES_W-1:0]    w_result_nxt;
    logic                w_err_nxt;
    logic                w_start_nxt;
    logic [DATA_W-1:0]   w_operand_nxt;
    logic [IDX_W-1:0]    w_win_nxt;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;

    logic                w_found;
    logic [IDX_W-1:0]    w_pick;
    logic [IDX_W-1:0]    w_cand;
    logic [DATA_W-1:0]   w_pick_op;

    // First requester at or above the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((32'(r_rr) + i) % NUM_REQ);
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_pick_op = operand_i[w_pick*DATA_W +: DATA_W];

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_done_nxt    = '0;
        w_result_nxt  = r_result;
        w_err_nxt     = 1'b0;
        w_start_nxt   = 1'b0;
        w_operand_nxt = r_operand;
        w_win_nxt     = r_win;
        w_rr_nxt      = r_rr;
        w_cnt_nxt     = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = S_LAUNCH;
                    w_win_nxt     = w_pick;
                    w_gnt_nxt     = ONE_HOT0 << w_pick;
                    w_operand_nxt = w_pick_op;
                    w_start_nxt   = 1'b1;
                end
            end
            S_LAUNCH: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the last watchdog cycle still wins.
                if (sq_done_i) begin
                    w_result_nxt = sq_root_i;
                    w_done_nxt   = r_gnt;
                    w_state_nxt  = S_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_result_nxt = '0;
                    w_done_nxt   = r_gnt;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_rr_nxt    = IDX_W'((32'(r_win) + 32'd1) % NUM_REQ);
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_done    <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_start   <= 1'b0;
            r_operand <= '0;
            r_win     <= '0;
            r_rr      <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_result  <= w_result_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_start   <= w_start_nxt;
            r_operand <= w_operand_nxt;
            r_win     <= w_win_nxt;
            r_rr      <= w_rr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign gnt_o        = r_gnt;
    assign done_o       = r_done;
    assign result_o     = r_result;
    assign err_o        = r_err;
    assign busy_o       = r_busy;
    assign sq_start_o   = r_start;
    assign sq_operand_o = r_operand;

endmodule
